agc_loop_ctrl: RTL and testbench
================================

Name: agc_loop_ctrl

Overview:
- Sequencer and configuration controller for the AGC datapath: envelope, accumulator, error gen, float emulation, integrator.
- Generates the decimation strobe that clocks the slow loop stages.
- Switches loop gain (mantissa/exp) between acquisition and tracking sets using a lock-detect FSM on the error signal.
- Freezes the integrator during hold/idle and applies software config atomically at strobe boundaries.

Parameters:
- DECIM, 8, fast-clock cycles per decimation strobe (>=2)
- LOCK_TOL, 64, |err| at or below this counts toward lock
- LOCK_N, 4, consecutive in-tolerance strobes needed to enter TRACK
- UNLOCK_TOL, 512, |err| above this counts toward loss of lock
- UNLOCK_N, 2, consecutive out-of-tolerance strobes needed to return to ACQ
- DEF_THRESH, 8'd128, reset threshold
- DEF_ACQ_MANT, 8'd192, reset acquisition mantissa
- DEF_ACQ_EXP, 4'd2, reset acquisition exponent
- DEF_TRK_MANT, 8'd128, reset tracking mantissa
- DEF_TRK_EXP, 4'd6, reset tracking exponent
- ACQ_TIMEOUT, 64, strobes (used only with the optional feature)

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  loop enable
- hold_req  in  1  request to freeze the loop (burst gap)
- err_in  in  15  signed loop error; sampled only on dec_stb cycles
- cfg_wr  in  1  config write strobe
- cfg_sel  in  3  0 = threshold, 1 = acq mant, 2 = acq exp, 3 = trk mant, 4 = trk exp; 5-7 ignored
- cfg_data  in  8  write data; exp uses bits [3:0]
- dec_stb  out  1  one-cycle decimation pulse
- threshold  out  8  active threshold
- mantissa  out  8  active loop-gain mantissa
- exp  out  4  active loop-gain exponent
- int_freeze  out  1  integrator hold
- state  out  2  IDLE = 0, ACQ = 1, TRACK = 2, HOLD = 3
- locked  out  1  high in TRACK, and in HOLD when entered from TRACK

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; counters 0.
  - dec_stb = 0, int_freeze = 1, locked = 0.
  - Shadow and active config take DEF_* values; threshold = DEF_THRESH, mantissa = DEF_ACQ_MANT, exp = DEF_ACQ_EXP.
- Decimation counter:
  - Counts 0..DECIM-1 while enable = 1; dec_stb = 1 when count == DECIM-1.
  - enable = 0 clears the count; first strobe comes DECIM cycles after enable rises.
- FSM (all registered):
  - enable = 0 from any state: IDLE on the next cycle; lock/unlock counters cleared.
  - IDLE -> ACQ on the cycle after enable = 1.
  - Remaining transitions are evaluated only on dec_stb cycles.
- Error magnitude: |err_in|; -16384 saturates to 16383.
- ACQ:
  - |err| <= LOCK_TOL increments lock_cnt; otherwise lock_cnt clears.
  - lock_cnt reaching LOCK_N -> TRACK.
- TRACK:
  - |err| > UNLOCK_TOL increments unlock_cnt; otherwise unlock_cnt clears.
  - unlock_cnt reaching UNLOCK_N -> ACQ.
- hold_req on a strobe in ACQ or TRACK -> HOLD.
  - Priority over lock/unlock transitions; the originating state is saved.
- HOLD: first strobe with hold_req = 0 returns to the saved state.
- All lock/unlock counters clear on every state entry.
- Config path:
  - cfg_wr writes the shadow register selected by cfg_sel in the same cycle.
  - Active registers copy the shadows on dec_stb cycles only.
  - cfg_wr on a strobe cycle: the new value is written to the shadow and becomes active at the next strobe.
- Outputs (registered):
  - mantissa/exp take the TRK set in TRACK (and in HOLD from TRACK), the ACQ set otherwise.
  - int_freeze = 1 in IDLE and HOLD.
  - Outputs reflect the new state one cycle after the transition strobe.

Optional Feature:
- Macro AGC_ACQ_TIMEOUT_EN.
- Defined:
  - Adds output acq_timeout (1 bit) and a strobe counter that runs in ACQ.
  - After ACQ_TIMEOUT strobes without lock: acq_timeout pulses for one cycle, the counter and lock_cnt clear, and the FSM stays in ACQ.
  - HOLD pauses the counter.
- Undefined: port and counter absent; ACQ persists indefinitely.

Decomposition:
- Package agc_pkg holds:
  - the state enum;
  - cfg_sel address constants;
  - width constants ERR_W = 15, MANT_W = 8, EXP_W = 4.
- One sub-module, agc_dec_strobe, implements the decimation counter and strobe.

Test Plan:
- Reset/enable: rst, then enable = 1 → state = ACQ next cycle; first dec_stb at cycle 8; int_freeze falls with ACQ; mantissa = 192, exp = 2.
- Lock: err_in = 40 for 4 strobes → state = TRACK, locked = 1, mantissa = 128, exp = 6; err = 40, 40, 100, 40, 40, 40, 40 delays lock to the 7th strobe.
- Unlock: in TRACK, err = -600, -600 → ACQ after 2nd strobe; err = -16384 is treated as 16383 and counts as out of tolerance.
- Hold: hold_req raised in TRACK → HOLD at next strobe, int_freeze = 1, locked = 1; drop hold_req → TRACK at following strobe.
- Config: cfg_wr sel = 3, data = 0x50 mid-period in TRACK → mantissa changes to 0x50 only one cycle after next dec_stb; enable low mid-ACQ → IDLE next cycle, strobe counter restarts.
- Timeout (AGC_ACQ_TIMEOUT_EN, ACQ_TIMEOUT = 64): err = 1000 constant → acq_timeout single pulse after 64th strobe, again after 128th.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC loop controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_pkg;

    localparam int ERR_W  = 15;
    localparam int MANT_W = 8;
    localparam int EXP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } agc_state_e;

    localparam logic [2:0] CFG_THRESH   = 3'd0;
    localparam logic [2:0] CFG_ACQ_MANT = 3'd1;
    localparam logic [2:0] CFG_ACQ_EXP  = 3'd2;
    localparam logic [2:0] CFG_TRK_MANT = 3'd3;
    localparam logic [2:0] CFG_TRK_EXP  = 3'd4;

    typedef struct packed {
        logic [MANT_W-1:0] thresh;
        logic [MANT_W-1:0] acq_mant;
        logic [EXP_W-1:0]  acq_exp;
        logic [MANT_W-1:0] trk_mant;
        logic [EXP_W-1:0]  trk_exp;
    } agc_cfg_t;

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// Control/status bundle between the AGC sequencer and its driver; AGC_ACQ_TIMEOUT_EN adds acq_timeout.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/strobe qualified.
interface agc_loop_ctrl_if;
    import agc_pkg::*;

    logic                    enable;
    logic                    hold_req;
    logic signed [ERR_W-1:0] err_in;
    logic                    cfg_wr;
    logic [2:0]              cfg_sel;
    logic [MANT_W-1:0]       cfg_data;

    logic                    dec_stb;
    logic [MANT_W-1:0]       threshold;
    logic [MANT_W-1:0]       mantissa;
    logic [EXP_W-1:0]        exp;
    logic                    int_freeze;
    agc_state_e              state;
    logic                    locked;
`ifdef AGC_ACQ_TIMEOUT_EN
    logic                    acq_timeout;
`endif

    modport master (
        output enable, hold_req, err_in, cfg_wr, cfg_sel, cfg_data,
        input  dec_stb, threshold, mantissa, exp, int_freeze, state, locked
`ifdef AGC_ACQ_TIMEOUT_EN
        , input acq_timeout
`endif
    );

    modport slave (
        input  enable, hold_req, err_in, cfg_wr, cfg_sel, cfg_data,
        output dec_stb, threshold, mantissa, exp, int_freeze, state, locked
`ifdef AGC_ACQ_TIMEOUT_EN
        , output acq_timeout
`endif
    );

endinterface

// File: rtl/agc_dec_strobe.sv
// Decimation counter: one-cycle dec_stb every DECIM enabled cycles.
// Latency: first strobe DECIM cycles after enable rises; enable low clears the count.
// Backpressure: none.
module agc_dec_strobe #(
    parameter int DECIM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic dec_stb
);

    localparam int            CW   = $clog2(DECIM);
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_q, stb_d;

    always_comb begin
        cnt_d = '0;
        stb_d = 1'b0;
        if (enable) begin
            stb_d = (cnt_q == LAST);
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end

    assign dec_stb = stb_q;

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC sequencer: decimation strobe, ACQ/TRACK/HOLD lock FSM, strobe-aligned config; AGC_ACQ_TIMEOUT_EN adds acq timeout.
// Latency: all outputs registered, new state visible one cycle after the deciding strobe.
// Backpressure: none; err_in/hold_req only sampled on dec_stb cycles.
module agc_loop_ctrl
    import agc_pkg::*;
#(
    parameter int                DECIM        = 8,
    parameter int                LOCK_TOL     = 64,
    parameter int                LOCK_N       = 4,
    parameter int                UNLOCK_TOL   = 512,
    parameter int                UNLOCK_N     = 2,
    parameter logic [MANT_W-1:0] DEF_THRESH   = 8'd128,
    parameter logic [MANT_W-1:0] DEF_ACQ_MANT = 8'd192,
    parameter logic [EXP_W-1:0]  DEF_ACQ_EXP  = 4'd2,
    parameter logic [MANT_W-1:0] DEF_TRK_MANT = 8'd128,
    parameter logic [EXP_W-1:0]  DEF_TRK_EXP  = 4'd6
`ifdef AGC_ACQ_TIMEOUT_EN
    , parameter int              ACQ_TIMEOUT  = 64
`endif
) (
    input  logic            clk,
    input  logic            rst,
    agc_loop_ctrl_if.slave  bus
);

    localparam int LCW = $clog2(LOCK_N + 1);
    localparam int UCW = $clog2(UNLOCK_N + 1);
    localparam logic [LCW-1:0]   LOCK_LAST   = LCW'(LOCK_N - 1);
    localparam logic [UCW-1:0]   UNLOCK_LAST = UCW'(UNLOCK_N - 1);
    localparam logic [ERR_W-2:0] LOCK_TOL_M   = (ERR_W-1)'(LOCK_TOL);
    localparam logic [ERR_W-2:0] UNLOCK_TOL_M = (ERR_W-1)'(UNLOCK_TOL);
    localparam agc_cfg_t DEF_CFG = '{DEF_THRESH, DEF_ACQ_MANT, DEF_ACQ_EXP,
                                     DEF_TRK_MANT, DEF_TRK_EXP};

    logic dec_stb;

    agc_dec_strobe #(.DECIM(DECIM)) u_dec_strobe (
        .clk     (clk),
        .rst     (rst),
        .enable  (bus.enable),
        .dec_stb (dec_stb)
    );

    agc_state_e        state_q, state_d, saved_q, saved_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [UCW-1:0]    unlock_cnt_q, unlock_cnt_d;
    agc_cfg_t          shadow_q, shadow_d, active_q, active_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              locked_q, locked_d, freeze_q, freeze_d;
`ifdef AGC_ACQ_TIMEOUT_EN
    localparam int            TOW     = $clog2(ACQ_TIMEOUT);
    localparam logic [TOW-1:0] TO_LAST = TOW'(ACQ_TIMEOUT - 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           to_pulse_q, to_pulse_d;
`endif

    // -16384 has no positive 15-bit twin; saturate it to 16383.
    logic [ERR_W-1:0] err_neg;
    logic [ERR_W-2:0] err_mag;
    logic             in_lock, out_lock;

    always_comb begin
        err_neg = -bus.err_in;
        err_mag = bus.err_in[ERR_W-2:0];
        if (bus.err_in[ERR_W-1]) begin
            err_mag = err_neg[ERR_W-1] ? '1 : err_neg[ERR_W-2:0];
        end
        in_lock  = (err_mag <= LOCK_TOL_M);
        out_lock = (err_mag > UNLOCK_TOL_M);
    end

    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
`ifdef AGC_ACQ_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        to_pulse_d   = 1'b0;
`endif
        if (bus.cfg_wr) begin
            case (bus.cfg_sel)
                CFG_THRESH:   shadow_d.thresh   = bus.cfg_data;
                CFG_ACQ_MANT: shadow_d.acq_mant = bus.cfg_data;
                CFG_ACQ_EXP:  shadow_d.acq_exp  = bus.cfg_data[EXP_W-1:0];
                CFG_TRK_MANT: shadow_d.trk_mant = bus.cfg_data;
                CFG_TRK_EXP:  shadow_d.trk_exp  = bus.cfg_data[EXP_W-1:0];
                default: ;
            endcase
        end
        // Copy the pre-write shadow so a same-cycle write lands at the following strobe.
        if (dec_stb) active_d = shadow_q;

        if (!bus.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQ;
                ST_ACQ: if (dec_stb) begin
                    if (bus.hold_req) begin
                        state_d = ST_HOLD;
                        saved_d = ST_ACQ;
                    end else begin
                        lock_cnt_d = in_lock ? lock_cnt_q + 1'b1 : '0;
                        if (in_lock && lock_cnt_q == LOCK_LAST) state_d = ST_TRACK;
`ifdef AGC_ACQ_TIMEOUT_EN
                        else if (to_cnt_q == TO_LAST) begin
                            to_cnt_d   = '0;
                            lock_cnt_d = '0;
                            to_pulse_d = 1'b1;
                        end else to_cnt_d = to_cnt_q + 1'b1;
`endif
                    end
                end
                ST_TRACK: if (dec_stb) begin
                    if (bus.hold_req) begin
                        state_d = ST_HOLD;
                        saved_d = ST_TRACK;
                    end else begin
                        unlock_cnt_d = out_lock ? unlock_cnt_q + 1'b1 : '0;
                        if (out_lock && unlock_cnt_q == UNLOCK_LAST) state_d = ST_ACQ;
                    end
                end
                ST_HOLD: if (dec_stb && !bus.hold_req) state_d = saved_q;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q || !bus.enable) begin
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
        end
`ifdef AGC_ACQ_TIMEOUT_EN
        // Returning from HOLD resumes the paused timeout count.
        if (state_d == ST_IDLE ||
            (state_d == ST_ACQ && state_q != ST_ACQ && state_q != ST_HOLD)) to_cnt_d = '0;
`endif
        locked_d = (state_d == ST_TRACK) || (state_d == ST_HOLD && saved_d == ST_TRACK);
        freeze_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
        mant_d   = locked_d ? active_d.trk_mant : active_d.acq_mant;
        exp_d    = locked_d ? active_d.trk_exp  : active_d.acq_exp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            saved_q      <= ST_IDLE;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            shadow_q     <= DEF_CFG;
            active_q     <= DEF_CFG;
            mant_q       <= DEF_ACQ_MANT;
            exp_q        <= DEF_ACQ_EXP;
            locked_q     <= 1'b0;
            freeze_q     <= 1'b1;
`ifdef AGC_ACQ_TIMEOUT_EN
            to_cnt_q     <= '0;
            to_pulse_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            mant_q       <= mant_d;
            exp_q        <= exp_d;
            locked_q     <= locked_d;
            freeze_q     <= freeze_d;
`ifdef AGC_ACQ_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            to_pulse_q   <= to_pulse_d;
`endif
        end
    end

    assign bus.dec_stb    = dec_stb;
    assign bus.threshold  = active_q.thresh;
    assign bus.mantissa   = mant_q;
    assign bus.exp        = exp_q;
    assign bus.int_freeze = freeze_q;
    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
`ifdef AGC_ACQ_TIMEOUT_EN
    assign bus.acq_timeout = to_pulse_q;
`endif

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Randomized bench for agc_loop_ctrl: a per-cycle reference model feeds a scoreboard queue.
// Latency: expectations target the cycle after each input cycle's clock edge.
// Backpressure: none; the monitor pops one expectation every cycle.
module tb_agc_loop_ctrl;

    localparam int DECIM = 8, LOCK_TOL = 64, LOCK_N = 4, UNLOCK_TOL = 512, UNLOCK_N = 2;
    localparam int ACQ_TO = 64;
    localparam int M_IDLE = 0, M_ACQ = 1, M_TRK = 2, M_HOLD = 3;

    logic clk = 1'b0;
    logic rst;
    agc_loop_ctrl_if bus();

    agc_loop_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    typedef struct {
        int stb; int st; int lk; int mant; int ex; int frz; int thr; int to;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;

    // Reference model: mode, streak of qualifying strobes, enabled-cycle count.
    int m_mode, m_from, m_streak, m_en_run, m_stb, m_acq_sc;
    int m_shadow[5];
    int m_active[5];
    int defaults[5] = '{128, 192, 2, 128, 6};

    task automatic apply(input bit r, input bit en, input bit hold, input int e,
                         input bit wr, input int sel, input int data);
        exp_t x;
        int   m, prev, pulse;
        rst          = r;
        bus.enable   = en;
        bus.hold_req = hold;
        bus.err_in   = 15'(e);
        bus.cfg_wr   = wr;
        bus.cfg_sel  = 3'(sel);
        bus.cfg_data = 8'(data);
        pulse = 0;
        if (r) begin
            m_mode = M_IDLE; m_from = M_IDLE; m_streak = 0; m_en_run = 0;
            m_stb = 0; m_acq_sc = 0; m_shadow = defaults; m_active = defaults;
        end else begin
            if (m_stb != 0) m_active = m_shadow;
            if (wr && sel < 5) m_shadow[sel] = (sel == 2 || sel == 4) ? data % 16 : data;
            prev = m_mode;
            m = (e < 0) ? -e : e;
            if (m > 16383) m = 16383;
            if (!en) m_mode = M_IDLE;
            else if (m_mode == M_IDLE) m_mode = M_ACQ;
            else if (m_stb != 0) begin
                if ((m_mode == M_ACQ || m_mode == M_TRK) && hold) begin
                    m_from = m_mode;
                    m_mode = M_HOLD;
                end else if (m_mode == M_ACQ) begin
                    m_streak = (m <= LOCK_TOL) ? m_streak + 1 : 0;
                    if (m_streak == LOCK_N) m_mode = M_TRK;
                    else begin
                        m_acq_sc++;
                        if (m_acq_sc == ACQ_TO) begin
                            pulse = 1; m_acq_sc = 0; m_streak = 0;
                        end
                    end
                end else if (m_mode == M_TRK) begin
                    m_streak = (m > UNLOCK_TOL) ? m_streak + 1 : 0;
                    if (m_streak == UNLOCK_N) m_mode = M_ACQ;
                end else if (!hold) begin
                    m_mode = m_from;
                end
            end
            if (m_mode != prev || !en) m_streak = 0;
            if (m_mode == M_IDLE || (m_mode == M_ACQ && prev != M_ACQ && prev != M_HOLD))
                m_acq_sc = 0;
            m_stb    = (en && ((m_en_run + 1) % DECIM) == 0) ? 1 : 0;
            m_en_run = en ? m_en_run + 1 : 0;
        end
        x.stb  = m_stb;
        x.st   = m_mode;
        x.lk   = (m_mode == M_TRK || (m_mode == M_HOLD && m_from == M_TRK)) ? 1 : 0;
        x.mant = (x.lk != 0) ? m_active[3] : m_active[1];
        x.ex   = (x.lk != 0) ? m_active[4] : m_active[2];
        x.frz  = (m_mode == M_IDLE || m_mode == M_HOLD) ? 1 : 0;
        x.thr  = m_active[0];
        x.to   = pulse;
        sb_q.push_back(x);
    endtask

    function automatic int pick_err(input int regime);
        int tbl[11] = '{64, -64, 65, -65, 512, -512, 513, -513, -16384, 16383, 0};
        case (regime)
            0, 3: begin
                if ($urandom_range(0, 7) == 0) return int'($urandom_range(65, 120));
                return int'($urandom_range(0, 128)) - 64;
            end
            1: case ($urandom_range(0, 3))
                0: return -16384;
                1: return -600;
                2: return int'($urandom_range(513, 16383));
                default: return -int'($urandom_range(513, 16383));
            endcase
            2: return int'($urandom_range(0, 32767)) - 16384;
            default: return tbl[$urandom_range(0, 10)];
        endcase
    endfunction

    // Stimulus
    initial begin
        bit hold;
        int regime;
        apply(1, 0, 0, 0, 0, 0, 0);
        repeat (2) begin @(negedge clk); apply(1, 0, 0, 0, 0, 0, 0); end
        repeat (2) begin @(negedge clk); apply(0, 0, 0, 0, 0, 0, 0); end
        hold = 1'b0;
        for (int seg = 0; seg < 40; seg++) begin
            regime = int'($urandom_range(0, 4));
            if (seg > 0 && $urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    apply(0, 0, 0, pick_err(regime), 0, 0, 0);
                end
            end
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                if (regime == 3) begin
                    if ($urandom_range(0, 23) == 0) hold = !hold;
                end else hold = 1'b0;
                apply(0, 1, hold, pick_err(regime), ($urandom_range(0, 15) == 0),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            end
        end
        // Long out-of-tolerance stretch: ACQ must persist (and time out when enabled).
        @(negedge clk); apply(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            apply(0, 1, 0, 1000, 0, 0, 0);
        end
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t x;
        int   cyc = 0;
        while (!(done && sb_q.size() == 0)) begin
            @(posedge clk);
            #2;
            cyc++;
            if (sb_q.size() == 0) begin
                if (!done) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_underflow cyc=%0d got empty queue want an entry", cyc);
                end
            end else begin
                x = sb_q.pop_front();
                n_checks++;
                if (int'(bus.dec_stb) != x.stb || int'(bus.state) != x.st ||
                    int'(bus.locked) != x.lk || int'(bus.mantissa) != x.mant ||
                    int'(bus.exp) != x.ex || int'(bus.int_freeze) != x.frz ||
                    int'(bus.threshold) != x.thr) begin
                    n_errors++;
                    $display("FAIL outputs cyc=%0d got stb=%0d st=%0d lk=%0d mant=%0d exp=%0d frz=%0d thr=%0d want stb=%0d st=%0d lk=%0d mant=%0d exp=%0d frz=%0d thr=%0d",
                             cyc, bus.dec_stb, bus.state, bus.locked, bus.mantissa, bus.exp,
                             bus.int_freeze, bus.threshold, x.stb, x.st, x.lk, x.mant, x.ex,
                             x.frz, x.thr);
                end
`ifdef AGC_ACQ_TIMEOUT_EN
                n_checks++;
                if (int'(bus.acq_timeout) != x.to) begin
                    n_errors++;
                    $display("FAIL acq_timeout cyc=%0d got %0d want %0d", cyc, bus.acq_timeout, x.to);
                end
`endif
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
